// File: rtl/alu_seq_ctrl.sv
// Single-issue sequencer between an instruction source and the external 4-bit ALU
// plus flag register. It holds a 4x4 register file and runs IDLE -> EXEC -> DONE per instruction.
module alu_seq_ctrl #(
  parameter logic [3:0] LDI_OPCODE = 4'b1111,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [13:0]      instr,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_enable,
  input  logic [3:0]       alu_result,
  output logic             flag_update,
  output logic             busy,
  output logic             done,
  input  logic [1:0]       rd_addr,
  output logic [3:0]       rd_data,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [3:0] imm_q;
  logic [3:0] opa_q;
  logic [3:0] opb_q;
  logic [3:0] rf [4];
  logic       accept;
  logic       alu_issue;

  // Handshake: a transfer happens on a rising edge where instr_valid and instr_ready
  // are both high; ready is high only in IDLE, and instr is sampled on that edge only.
  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;

  assign busy      = (state == EXEC) || (state == DONE);
  assign done      = (state == DONE);
  assign alu_issue = (state == EXEC) && (op_q != LDI_OPCODE);

  // ALU-facing outputs decode only from registered state, so they are clean zeros elsewhere.
  assign alu_a       = alu_issue ? opa_q : 4'd0;
  assign alu_b       = alu_issue ? opb_q : 4'd0;
  assign alu_opcode  = alu_issue ? op_q  : 4'd0;
  assign alu_enable  = alu_issue;
  assign flag_update = alu_issue;

  assign rd_data = rf[rd_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands are snapshotted at accept, so rd may alias rs1/rs2 safely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= 4'd0;
      rd_q  <= 2'd0;
      imm_q <= 4'd0;
      opa_q <= 4'd0;
      opb_q <= 4'd0;
    end else if (accept) begin
      op_q  <= instr[13:10];
      rd_q  <= instr[9:8];
      imm_q <= instr[3:0];
      opa_q <= rf[instr[7:6]];
      opb_q <= rf[instr[5:4]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
    end else if (state == EXEC) begin
      rf[rd_q] <= (op_q == LDI_OPCODE) ? imm_q : alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if ((state == DONE) && (retired != {CNT_W{1'b1}})) begin
      retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU and flag register attached;
// writebacks are predicted into exp_q at issue time and popped when done pulses.
module tb_alu_seq_ctrl;

  localparam logic [3:0] LDI = 4'b1111;
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] SRA = 4'b1010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [13:0] instr = 14'd0;
  logic [3:0]  alu_a, alu_b, alu_opcode, alu_result;
  logic        alu_enable, flag_update, busy, done;
  logic [1:0]  rd_addr = 2'd0;
  logic [3:0]  rd_data;
  logic [7:0]  retired;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_enable(alu_enable), .alu_result(alu_result), .flag_update(flag_update),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data), .retired(retired)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- ALU and flag register models ----------------
  function automatic logic [4:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      ADD:     alu_fn = {1'b0, a} + {1'b0, b};
      SUB:     alu_fn = {1'b0, a} - {1'b0, b};
      SRA:     alu_fn = {1'b0, a[3], a[3:1]};
      default: alu_fn = {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [3:0] flag_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                         input logic [4:0] full);
    logic v;
    v = 1'b0;
    if (op == ADD) v = (a[3] == b[3]) && (full[3] != a[3]);
    if (op == SUB) v = (a[3] != b[3]) && (full[3] != a[3]);
    flag_fn = {(full[3:0] == 4'd0), full[3], full[4], v};
  endfunction

  logic [4:0] alu_full;
  logic [3:0] flags;
  assign alu_full   = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_full[3:0];

  always @(posedge clk or negedge reset) begin
    if (!reset) flags <= 4'd0;
    else if (flag_update) flags <= flag_fn(alu_opcode, alu_a, alu_b, alu_full);
  end

  // ---------------- scoreboard ----------------
  int         tests = 0;
  int         fails = 0;
  logic [5:0] exp_q[$];
  logic [3:0] m_rf [4];
  logic [7:0] exp_ret;
  int         last_accept;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge inside the DONE cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [3:0] imm, input bit hold, input bit b2b);
    logic [3:0] a, b, res, old;
    logic [4:0] full;
    logic [5:0] entry;
    logic       is_alu;
    int         n;
    a      = m_rf[rs1];
    b      = m_rf[rs2];
    old    = m_rf[rd];
    full   = alu_fn(op, a, b);
    is_alu = (op != LDI);
    res    = is_alu ? full[3:0] : imm;
    m_rf[rd] = res;
    exp_q.push_back({rd, res});

    instr       = {op, rd, rs1, rs2, imm};
    instr_valid = 1'b1;
    n = 0;
    while (instr_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 8'(n < 8), 8'd1);
    @(posedge clk);
    @(negedge clk);
    if (b2b) check("b2b_spacing", 8'(cyc - last_accept), 8'd3);
    last_accept = cyc;
    if (!hold) instr_valid = 1'b0;

    // EXEC cycle
    check("exec_busy", busy, 1);
    check("exec_ready", instr_ready, 0);
    check("exec_done", done, 0);
    check("exec_alu_en", alu_enable, is_alu);
    check("exec_flag_upd", flag_update, is_alu);
    check("exec_opcode", alu_opcode, is_alu ? op : 4'd0);
    check("exec_alu_a", alu_a, is_alu ? a : 4'd0);
    check("exec_alu_b", alu_b, is_alu ? b : 4'd0);
    rd_addr = rd;
    #1 check("exec_rd_old", rd_data, old);

    // DONE cycle
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_ready", instr_ready, 0);
    check("done_alu_en", alu_enable, 0);
    check("done_flag_upd", flag_update, 0);
    check("done_opcode", alu_opcode, 0);
    check("done_retired", retired, exp_ret);
    if (exp_ret != 8'hff) exp_ret = exp_ret + 8'd1;
    entry   = exp_q.pop_front();
    rd_addr = entry[5:4];
    #1 check("writeback", rd_data, entry[3:0]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] f0;
    for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
    exp_ret     = 8'd0;
    last_accept = 0;

    // reset state
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_alu_en", alu_enable, 0);
    check("rst_flag_upd", flag_update, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_retired", retired, 0);
    check("rst_rf0", rd_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);

    // LDI, LDI, ADD
    issue(LDI, 2'd0, 2'd0, 2'd0, 4'd3, 0, 0);
    issue(LDI, 2'd1, 2'd0, 2'd0, 4'd4, 0, 0);
    issue(ADD, 2'd2, 2'd0, 2'd1, 4'd0, 0, 0);
    check("add_flags", flags, 4'b0000);
    @(negedge clk);
    check("retired_3", retired, 3);

    // snapshot semantics: r3 = r3 - r0 with r3 = 5
    issue(LDI, 2'd3, 2'd0, 2'd0, 4'd5, 0, 0);
    issue(SUB, 2'd3, 2'd3, 2'd0, 4'd0, 0, 0);

    // back-to-back with instr_valid held high
    issue(LDI, 2'd2, 2'd0, 2'd0, 4'd9, 1, 0);
    issue(ADD, 2'd0, 2'd2, 2'd3, 4'd0, 1, 1);
    issue(SUB, 2'd1, 2'd0, 2'd2, 4'd0, 1, 1);
    issue(LDI, 2'd3, 2'd0, 2'd0, 4'd6, 0, 1);

    // LDI leaves flags alone, then SRA
    f0 = flags;
    issue(LDI, 2'd1, 2'd0, 2'd0, 4'b1001, 0, 0);
    check("ldi_flags_hold", flags, f0);
    issue(SRA, 2'd1, 2'd1, 2'd0, 4'd0, 0, 0);
    rd_addr = 2'd1;
    #1 check("sra_result", rd_data, 4'b1100);

    // reset in the middle of EXEC
    @(negedge clk);
    instr       = {ADD, 2'd0, 2'd1, 2'd2, 4'd0};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("mid_exec_alu_en", alu_enable, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", instr_ready, 1);
    check("mid_rst_flag_upd", flag_update, 0);
    check("mid_rst_retired", retired, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 check("mid_rst_rf", rd_data, 0);
    end
    @(negedge clk);
    check("mid_rst_no_done", done, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", instr_ready, 1);
    check("rel_no_done", done, 0);
    check("rel_retired", retired, 0);
    for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
    exp_ret = 8'd0;

    // retired counter saturation
    for (int i = 0; i < 260; i++) begin
      issue(LDI, 2'($urandom_range(0, 3)), 2'd0, 2'd0, 4'($urandom_range(0, 15)), 0, 0);
    end
    repeat (2) @(negedge clk);
    check("retired_sat", retired, 8'hff);

    check("exp_q_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
